// File: rtl/grayscale_pkg.sv
// Shared constants for the streaming RGB-to-grayscale converter:
// mode encodings, luma coefficient sets (1/256 units) and fixed-point scaling.
package grayscale_pkg;

    typedef enum logic [1:0] {
        GS_MODE_601   = 2'd0,
        GS_MODE_709   = 2'd1,
        GS_MODE_AVG   = 2'd2,
        GS_MODE_GREEN = 2'd3
    } gs_mode_t;

    typedef struct packed {
        logic [8:0] r;
        logic [8:0] g;
        logic [8:0] b;
    } gs_coef_t;

    // Each coefficient set sums to 256 so a full-scale white maps to full scale.
    localparam logic [8:0] GS_COEF_601_R   = 9'd77;
    localparam logic [8:0] GS_COEF_601_G   = 9'd150;
    localparam logic [8:0] GS_COEF_601_B   = 9'd29;
    localparam logic [8:0] GS_COEF_709_R   = 9'd54;
    localparam logic [8:0] GS_COEF_709_G   = 9'd183;
    localparam logic [8:0] GS_COEF_709_B   = 9'd19;
    localparam logic [8:0] GS_COEF_AVG_R   = 9'd85;
    localparam logic [8:0] GS_COEF_AVG_G   = 9'd86;
    localparam logic [8:0] GS_COEF_AVG_B   = 9'd85;
    localparam logic [8:0] GS_COEF_GREEN_R = 9'd0;
    localparam logic [8:0] GS_COEF_GREEN_G = 9'd256;
    localparam logic [8:0] GS_COEF_GREEN_B = 9'd0;

    localparam int GS_FRAC_BITS  = 8;
    localparam int GS_ROUND_BIAS = 128;

endpackage

// File: rtl/gs_coef_lut.sv
// Combinational lookup from coefficient-set select to the three luma weights.
module gs_coef_lut
    import grayscale_pkg::*;
(
    input  logic [1:0] i_mode,
    output gs_coef_t   o_coef
);

    // Decode the mode into its {R,G,B} weight triple.
    always_comb begin
        o_coef = '{r: GS_COEF_601_R, g: GS_COEF_601_G, b: GS_COEF_601_B};
        case (i_mode)
            GS_MODE_601:   o_coef = '{r: GS_COEF_601_R,   g: GS_COEF_601_G,   b: GS_COEF_601_B};
            GS_MODE_709:   o_coef = '{r: GS_COEF_709_R,   g: GS_COEF_709_G,   b: GS_COEF_709_B};
            GS_MODE_AVG:   o_coef = '{r: GS_COEF_AVG_R,   g: GS_COEF_AVG_G,   b: GS_COEF_AVG_B};
            GS_MODE_GREEN: o_coef = '{r: GS_COEF_GREEN_R, g: GS_COEF_GREEN_G, b: GS_COEF_GREEN_B};
            default:       o_coef = '{r: GS_COEF_601_R,   g: GS_COEF_601_G,   b: GS_COEF_601_B};
        endcase
    end

endmodule

// File: rtl/grayscale_stream.sv
// Streaming RGB-to-grayscale converter. Two-stage pipeline (multiply, then
// sum/round/shift/saturate) with a combinational ready chain so that a full
// pipe can still accept a beat in the same cycle the output is taken.
// Frame/line sideband travels alongside each pixel.
module grayscale_stream
    import grayscale_pkg::*;
#(
    parameter  int P_SUBPIXEL_DEPTH = 8,
    parameter  int P_ROUND          = 1,
    localparam int P_PIXEL_DEPTH    = 3 * P_SUBPIXEL_DEPTH
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [P_PIXEL_DEPTH-1:0]    I_PIXEL,
    input  logic                        I_VALID,
    output logic                        O_READY,
    input  logic                        I_SOF,
    input  logic                        I_EOL,
    input  logic [1:0]                  I_MODE,
    output logic [P_SUBPIXEL_DEPTH-1:0] O_PIXEL,
    output logic                        O_VALID,
    input  logic                        I_READY,
    output logic                        O_SOF,
    output logic                        O_EOL
);

    localparam int N = P_SUBPIXEL_DEPTH;

    logic           w_en1;
    logic           w_en2;
    logic           w_accept;
    logic [1:0]     w_mode_eff;
    gs_coef_t       w_coef;
    logic [N+8:0]   w_prod_r;
    logic [N+8:0]   w_prod_g;
    logic [N+8:0]   w_prod_b;
    logic [N+9:0]   w_bias;
    logic [N+9:0]   w_sum;
    logic [N+9:0]   w_shift;
    logic [N-1:0]   w_gray;

    logic [1:0]     r_mode;
    logic           r_v1;
    logic [N+8:0]   r_prod_r;
    logic [N+8:0]   r_prod_g;
    logic [N+8:0]   r_prod_b;
    logic           r_sof1;
    logic           r_eol1;
    logic           r_v2;
    logic [N-1:0]   r_pix2;
    logic           r_sof2;
    logic           r_eol2;

    // Ready chain: a stage may load when it is empty or the stage after it moves.
    always_comb begin
        w_en2    = ~r_v2 | I_READY;
        w_en1    = ~r_v1 | w_en2;
        w_accept = I_VALID & w_en1;
    end

    // A SOF beat applies its own mode immediately; other beats use the held mode.
    always_comb begin
        w_mode_eff = I_SOF ? I_MODE : r_mode;
    end

    gs_coef_lut u_coef_lut (
        .i_mode (w_mode_eff),
        .o_coef (w_coef)
    );

    // Stage-1 products, zero-extended to N+9 bits so no partial product is lost.
    always_comb begin
        w_prod_r = (N+9)'(I_PIXEL[3*N-1:2*N]) * (N+9)'(w_coef.r);
        w_prod_g = (N+9)'(I_PIXEL[2*N-1:N])   * (N+9)'(w_coef.g);
        w_prod_b = (N+9)'(I_PIXEL[N-1:0])     * (N+9)'(w_coef.b);
    end

    // Mode register: latched only on an accepted start-of-frame beat.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_mode <= 2'd0;
        end else if (w_accept && I_SOF) begin
            r_mode <= I_MODE;
        end
    end

    // Stage-1 valid bit.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_v1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= w_accept;
        end
    end

    // Stage-1 data and sideband; gated by r_v1 so no reset is needed.
    always_ff @(posedge I_CLK) begin
        if (w_en1) begin
            r_prod_r <= w_prod_r;
            r_prod_g <= w_prod_g;
            r_prod_b <= w_prod_b;
            r_sof1   <= I_SOF;
            r_eol1   <= I_EOL;
        end
    end

    // Sum, optional round-to-nearest, drop fraction bits, clamp to N bits.
    always_comb begin
        w_bias  = (P_ROUND != 0) ? (N+10)'(GS_ROUND_BIAS) : '0;
        w_sum   = (N+10)'(r_prod_r) + (N+10)'(r_prod_g) + (N+10)'(r_prod_b) + w_bias;
        w_shift = w_sum >> GS_FRAC_BITS;
        if (|w_shift[N+9:N]) begin
            w_gray = '1;
        end else begin
            w_gray = w_shift[N-1:0];
        end
    end

    // Stage-2 output register; holds while the downstream stalls.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_v2   <= 1'b0;
            r_pix2 <= '0;
            r_sof2 <= 1'b0;
            r_eol2 <= 1'b0;
        end else if (w_en2) begin
            r_v2   <= r_v1;
            r_pix2 <= w_gray;
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
        end
    end

    // Output port mapping.
    always_comb begin
        O_READY = w_en1;
        O_VALID = r_v2;
        O_PIXEL = r_pix2;
        O_SOF   = r_sof2;
        O_EOL   = r_eol2;
    end

endmodule

// File: tb/tb_grayscale_stream.sv
// Directed bench for grayscale_stream: a rounding and a truncating instance
// share one input stream; a scoreboard checks every output beat in order.
module tb_grayscale_stream;

    logic        I_CLK;
    logic        I_RESET;
    logic [23:0] I_PIXEL;
    logic        I_VALID;
    logic        I_SOF;
    logic        I_EOL;
    logic [1:0]  I_MODE;
    logic        I_READY;

    logic        O_READY;
    logic [7:0]  O_PIXEL;
    logic        O_VALID;
    logic        O_SOF;
    logic        O_EOL;

    logic        O_READY_T;
    logic [7:0]  O_PIXEL_T;
    logic        O_VALID_T;
    logic        O_SOF_T;
    logic        O_EOL_T;

    grayscale_stream #(.P_SUBPIXEL_DEPTH(8), .P_ROUND(1)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_PIXEL(I_PIXEL), .I_VALID(I_VALID),
        .O_READY(O_READY), .I_SOF(I_SOF), .I_EOL(I_EOL), .I_MODE(I_MODE),
        .O_PIXEL(O_PIXEL), .O_VALID(O_VALID), .I_READY(I_READY),
        .O_SOF(O_SOF), .O_EOL(O_EOL)
    );

    grayscale_stream #(.P_SUBPIXEL_DEPTH(8), .P_ROUND(0)) dut_t (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_PIXEL(I_PIXEL), .I_VALID(I_VALID),
        .O_READY(O_READY_T), .I_SOF(I_SOF), .I_EOL(I_EOL), .I_MODE(I_MODE),
        .O_PIXEL(O_PIXEL_T), .O_VALID(O_VALID_T), .I_READY(I_READY),
        .O_SOF(O_SOF_T), .O_EOL(O_EOL_T)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] pix_t;
        logic       sof;
        logic       eol;
    } exp_t;

    typedef struct {
        logic       sof;
        logic       eol;
        logic [1:0] mode;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] exp_r;
        logic [7:0] exp_t;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];
    int   out_cyc[$];

    logic       have_hold = 1'b0;
    logic [7:0] hold_pix;
    logic       hold_sof;
    logic       hold_eol;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge I_CLK) cyc <= cyc + 1;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge I_CLK) begin
        if (!I_RESET) begin
            if (O_VALID && !I_READY) begin
                if (have_hold) begin
                    chk("hold_pix", int'(O_PIXEL), int'(hold_pix));
                    chk("hold_sof", int'(O_SOF), int'(hold_sof));
                    chk("hold_eol", int'(O_EOL), int'(hold_eol));
                end
                have_hold = 1'b1;
                hold_pix  = O_PIXEL;
                hold_sof  = O_SOF;
                hold_eol  = O_EOL;
            end else begin
                have_hold = 1'b0;
            end
            if (O_VALID && I_READY) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got pixel %0d, expected no beat", O_PIXEL);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_pix", int'(O_PIXEL), int'(e.pix));
                    chk("out_pix_trunc", int'(O_PIXEL_T), int'(e.pix_t));
                    chk("out_valid_trunc", int'(O_VALID_T), 1);
                    chk("out_sof", int'(O_SOF), int'(e.sof));
                    chk("out_eol", int'(O_EOL), int'(e.eol));
                    out_cyc.push_back(cyc);
                end
            end
        end else begin
            have_hold = 1'b0;
        end
    end

    // Offer one beat until accepted (bounded), then queue its expected output.
    task automatic send(input logic sof, input logic eol, input logic [1:0] mode,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] exp_r, input logic [7:0] exp_tr);
        logic acc;
        exp_t e;
        I_VALID = 1'b1;
        I_SOF   = sof;
        I_EOL   = eol;
        I_MODE  = mode;
        I_PIXEL = {r, g, b};
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge I_CLK);
            acc = O_READY;
            @(posedge I_CLK);
            #1;
        end
        I_VALID = 1'b0;
        I_SOF   = 1'b0;
        I_EOL   = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got O_READY 0 for 100 cycles, expected 1");
        end else begin
            e.pix   = exp_r;
            e.pix_t = exp_tr;
            e.sof   = sof;
            e.eol   = eol;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge I_CLK);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", q.size());
        end
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t0;
        vecs[0] = '{1'b1, 1'b0, 2'd0, 8'd255, 8'd0,   8'd0,   8'd77,  8'd76};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 8'd0,   8'd255, 8'd0,   8'd182, 8'd182};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd255, 8'd0,   8'd182, 8'd182};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 8'd30,  8'd60,  8'd90,  8'd60,  8'd60};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 8'd12,  8'd200, 8'd7,   8'd200, 8'd200};
        vecs[6] = '{1'b0, 1'b1, 2'd2, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        vecs[7] = '{1'b1, 1'b0, 2'd0, 8'd0,   8'd0,   8'd255, 8'd29,  8'd28};
        vecs[8] = '{1'b1, 1'b0, 2'd1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vecs[9] = '{1'b0, 1'b0, 2'd3, 8'd100, 8'd50,  8'd200, 8'd72,  8'd71};

        I_RESET = 1'b1;
        I_PIXEL = '0;
        I_VALID = 1'b0;
        I_SOF   = 1'b0;
        I_EOL   = 1'b0;
        I_MODE  = 2'd0;
        I_READY = 1'b1;
        repeat (3) @(posedge I_CLK);
        #1 I_RESET = 1'b0;

        @(negedge I_CLK);
        chk("rst_valid", int'(O_VALID), 0);
        chk("rst_pixel", int'(O_PIXEL), 0);
        chk("rst_sof", int'(O_SOF), 0);
        chk("rst_eol", int'(O_EOL), 0);
        chk("rst_ready", int'(O_READY), 1);
        @(posedge I_CLK);
        #1;

        // Two-cycle latency of the first beat after reset.
        send(1'b1, 1'b0, 2'd0, 8'd255, 8'd0, 8'd0, 8'd77, 8'd76);
        @(negedge I_CLK);
        chk("lat_valid_c1", int'(O_VALID), 0);
        @(negedge I_CLK);
        chk("lat_valid_c2", int'(O_VALID), 1);
        chk("lat_pixel", int'(O_PIXEL), 77);
        chk("lat_sof", int'(O_SOF), 1);
        @(posedge I_CLK);
        #1;
        drain();

        // Table vectors streamed back to back.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].sof, vecs[i].eol, vecs[i].mode, vecs[i].r, vecs[i].g,
                 vecs[i].b, vecs[i].exp_r, vecs[i].exp_t);
        end
        drain();

        // Backpressure: 5-cycle downstream stall mid-stream.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(i == 0, 1'b0, 2'd3, 8'd0, 8'((i + 1) * 10), 8'd0,
                         8'((i + 1) * 10), 8'((i + 1) * 10));
                end
            end
            begin
                repeat (3) @(posedge I_CLK);
                #1 I_READY = 1'b0;
                repeat (5) @(negedge I_CLK);
                chk("bp_ready_low", int'(O_READY), 0);
                chk("bp_valid_high", int'(O_VALID), 1);
                @(posedge I_CLK);
                #1 I_READY = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight; new frame mode 2 must be forgotten.
        I_READY = 1'b0;
        send(1'b1, 1'b0, 2'd2, 8'd30, 8'd60, 8'd90, 8'd60, 8'd60);
        send(1'b0, 1'b0, 2'd2, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90);
        I_RESET = 1'b1;
        @(posedge I_CLK);
        #1 I_RESET = 1'b0;
        q.delete();
        @(negedge I_CLK);
        chk("flush_valid", int'(O_VALID), 0);
        chk("flush_pixel", int'(O_PIXEL), 0);
        I_READY = 1'b1;
        repeat (4) @(posedge I_CLK);
        #1;
        send(1'b0, 1'b0, 2'd1, 8'd0, 8'd255, 8'd0, 8'd149, 8'd149);
        drain();

        // EOL on beat 4 of 8 at full throughput.
        n0 = out_cyc.size();
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, i == 3, 2'd3, 8'd5, 8'(11 + i), 8'd9, 8'(11 + i), 8'(11 + i));
        end
        chk("tput_in_cycles", cyc - t0, 8);
        drain();
        chk("tput_out_count", out_cyc.size() - n0, 8);
        if (out_cyc.size() - n0 == 8) begin
            chk("tput_out_span", out_cyc[n0 + 7] - out_cyc[n0], 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
